// File: rtl/alu_chk_pkg.sv
// Shared constants and types for the ALU result checker and its reference model.
// Opcode encoding, FSM state encoding and the result width live here.
package alu_chk_pkg;

  localparam int RES_W = 9;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Snapshot of the first failing comparison.
  typedef struct packed {
    logic [RES_W-1:0] got;
    logic [RES_W-1:0] exp;
  } fail_rec_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference model of simple_alu: 8-bit operands, 9-bit result.
// Operands are zero-extended; for subtraction bit 8 is the borrow.
module alu_ref_model
  import alu_chk_pkg::*;
(
  input  logic [7:0]       op_a_i,
  input  logic [7:0]       op_b_i,
  input  logic [1:0]       op_i,
  output logic [RES_W-1:0] result_o
);

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  assign a_ext = {1'b0, op_a_i};
  assign b_ext = {1'b0, op_b_i};

  always_comb begin
    // NOTE: assign a default before the case so no path can infer a latch.
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_ext + b_ext;
      OP_SUB:  result_o = a_ext - b_ext;
      OP_AND:  result_o = a_ext & b_ext;
      OP_OR:   result_o = a_ext | b_ext;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// Delays the reference result of each issued tuple by ALU_LAT cycles, compares it with
// the ALU output and keeps run statistics. Define CHK_STOP_ON_FAIL_EN to end a run at the first mismatch.
module alu_result_checker
  import alu_chk_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             issue_valid,
  input  logic [7:0]       opA,
  input  logic [7:0]       opB,
  input  logic [1:0]       op,
  input  logic [RES_W-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] fail_idx,
  output logic [RES_W-1:0] fail_got,
  output logic [RES_W-1:0] fail_exp
);

  logic [RES_W-1:0] model_res;

  alu_ref_model u_ref (
    .op_a_i   (opA),
    .op_b_i   (opB),
    .op_i     (op),
    .result_o (model_res)
  );

  // Delay line: loaded every cycle, regardless of FSM state.
  logic [ALU_LAT-1:0] dl_vld_q;
  logic [RES_W-1:0]   dl_exp_q [ALU_LAT];

  // NOTE: sequential state uses non-blocking assignments so every stage samples the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_vld_q <= '0;
    end else begin
      dl_vld_q[0] <= issue_valid;
      for (int i = 1; i < ALU_LAT; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
      end
    end
  end

  // NOTE: payload only; validity is tracked in dl_vld_q, so this array needs no reset.
  always_ff @(posedge clk) begin
    dl_exp_q[0] <= model_res;
    for (int i = 1; i < ALU_LAT; i++) begin
      dl_exp_q[i] <= dl_exp_q[i-1];
    end
  end

  logic             cmp_valid;
  logic [RES_W-1:0] cmp_exp;
  logic             mismatch;

  assign cmp_valid = dl_vld_q[ALU_LAT-1];
  assign cmp_exp   = dl_exp_q[ALU_LAT-1];
  assign mismatch  = cmp_valid && (alu_result != cmp_exp);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] num_q,   num_d;
  logic [CNT_W-1:0] vec_q,   vec_d;
  logic [CNT_W-1:0] err_q,   err_d;
  logic [CNT_W-1:0] fidx_q,  fidx_d;
  fail_rec_t        frec_q,  frec_d;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    frec_d  = frec_q;

    // start wins over any comparison in the same cycle, in every state.
    if (start) begin
      state_d = (num_vectors == '0) ? ST_DONE : ST_RUN;
      num_d   = num_vectors;
      vec_d   = '0;
      err_d   = '0;
      fidx_d  = '0;
      frec_d  = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cmp_valid) begin
            vec_d = vec_q + 1'b1;
            if (mismatch) begin
              if (err_q != '1) begin
                err_d = err_q + 1'b1;
              end
              if (err_q == '0) begin
                fidx_d     = vec_q;
                frec_d.got = alu_result;
                frec_d.exp = cmp_exp;
              end
            end
            if (vec_d == num_q) begin
              state_d = ST_DONE;
            end
`ifdef CHK_STOP_ON_FAIL_EN
            if (mismatch) begin
              state_d = ST_DONE;
            end
`endif
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      frec_q  <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      frec_q  <= frec_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_q == '0);
  assign vec_count = vec_q;
  assign err_count = err_q;
  assign fail_idx  = fidx_q;
  assign fail_got  = frec_q.got;
  assign fail_exp  = frec_q.exp;

endmodule
